iob_cache_ctrl_sampler: RTL
===========================

# iob_cache_ctrl_sampler

Periodic statistics sampler sitting directly downstream of the cache control/counter block; it drives that block's request port (`valid`/`addr`) and consumes its `rdata`/`ready` replies. Every programmed period it reads the four hit/miss counters in a fixed sequence and latches them into a coherent snapshot. It offers the snapshot to a host over a valid/ready handshake and raises a miss-threshold alarm.

## Interface
- `DATA_W`, 32: counter/snapshot width; must equal the control block's `DATA_W`.
- `PERIOD_W`, 16: width of the sample-period counter.
- `TMO_W`, 4: width of the per-read reply timeout counter; timeout = 2^TMO_W−1 cycles.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset; one clock, synchronous, active-low.
- `enable_i` in 1: sampling enabled; sampled at each period expiry.
- `period_i` in PERIOD_W: cycles between sample starts; 0 treated as 1.
- `miss_thresh_i` in DATA_W: alarm threshold on the summed miss count.
- `ctrl_valid_o` out 1: request strobe to the control block.
- `ctrl_addr_o` out `IOB_CACHE_SWREG_ADDR_W`: request address.
- `ctrl_rdata_i` in DATA_W: reply data.
- `ctrl_ready_i` in 1: reply strobe.
- `snap_valid_o` out 1: snapshot available.
- `snap_ready_i` in 1: host accepts snapshot.
- `snap_rd_hit_o`, `snap_rd_miss_o`, `snap_wr_hit_o`, `snap_wr_miss_o` out DATA_W each: snapshot fields.
- `miss_alarm_o` out 1: sticky, set when a snapshot's `rd_miss + wr_miss > miss_thresh_i`.
- `overrun_o` out 1: sticky, set when a period expires while `snap_valid_o` is still high.
- `err_o` out 1: sticky, set on reply timeout.
- `clr_flags_i` in 1: clears `miss_alarm_o`, `overrun_o`, `err_o`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, CLEAR, CLRWAIT.
- Period counter:
  - Counts up every cycle the FSM is in IDLE.
  - On reaching `period_i−1` it wraps to 0 and, if `enable_i`, moves the FSM to ISSUE with index 0.
  - If `snap_valid_o` is still high at expiry, no sample starts and `overrun_o` sets.
- Read sequence, index 0..3: `IOB_CACHE_READ_HIT_ADDR`, `READ_MISS`, `WRITE_HIT`, `WRITE_MISS`.
- ISSUE:
  - Drives `ctrl_valid_o`=1 for exactly one cycle with `ctrl_addr_o` = address for the current index.
  - Then goes to WAIT.
- WAIT:
  - `ctrl_valid_o`=0.
  - On `ctrl_ready_i`: capture `ctrl_rdata_i` into the shadow field for the current index. If index<3, increment it and go to ISSUE; otherwise go to DONE.
  - Timeout counter overflow: set `err_o`, discard the shadow values, go to IDLE.
- DONE:
  - Copy all four shadow fields to the snapshot outputs in one cycle.
  - Set `snap_valid_o`.
  - Evaluate the alarm using a DATA_W+1-bit sum; the carry counts as exceeding the threshold.
  - Go to CLEAR if the auto-clear macro is defined, else IDLE.
- Snapshot outputs change only in DONE, so a held snapshot is always coherent.
- `snap_valid_o` clears on the cycle after `snap_valid_o && snap_ready_i`.
- `ctrl_ready_i` outside WAIT/CLRWAIT is ignored.
- `clr_flags_i` coinciding with a set event: the set wins.
- `enable_i` deasserted mid-sequence: the sequence completes; no new sample starts.

## Timing
- Reset values:
  - All outputs 0; `ctrl_addr_o`=0.
  - FSM in IDLE; period counter 0.
- Control block replies one cycle after the request, so each read takes 2 cycles.
- Sequence latency: first ISSUE to `snap_valid_o` high = 9 cycles (8 read cycles + DONE).
- Never more than one outstanding request.
- `ctrl_valid_o` is never high in two consecutive cycles.
- Reset mid-sequence: the FSM returns to IDLE immediately; no partial snapshot is exposed.

## Configuration
- `IOB_CACHE_SAMPLER_AUTO_CLEAR_EN` defined:
  - After DONE, the FSM enters CLEAR and issues one `ctrl_valid_o` with `IOB_CACHE_RST_CNTRS_ADDR`.
  - CLRWAIT then waits for `ctrl_ready_i`, with the same timeout and `err_o` rule, and returns to IDLE.
  - Each snapshot covers exactly one period; sequence length is 11 cycles.
- Undefined:
  - CLEAR/CLRWAIT are absent and the counters accumulate.
  - The RST_CNTRS address is never driven.

## Test plan
- Reset with `period_i`=20, `enable_i`=1, control model returning 5/1/7/2 -> first ISSUE on cycle 20 after reset release; snapshot 5/1/7/2 with `snap_valid_o` high 9 cycles later; `miss_alarm_o` stays 0 with `miss_thresh_i`=3.
- Same stimulus with `miss_thresh_i`=2 -> `miss_alarm_o`=1 (sum 3); `clr_flags_i` pulse -> 0.
- Hold `snap_ready_i`=0 across two periods -> `overrun_o`=1 and snapshot unchanged; `snap_ready_i`=1 -> `snap_valid_o` low the next cycle, and a new sample starts at the next expiry.
- Control model withholds `ctrl_ready_i` on the READ_MISS read -> `err_o`=1 after 15 cycles; FSM back in IDLE; no `snap_valid_o`.
- Macro defined -> exactly one RST_CNTRS request per sample, issued 9 cycles after the first ISSUE; the next snapshot reflects only the new period's events.
- `reset_n_i` low during WAIT of index 2 -> `ctrl_valid_o`=0 and all outputs 0 the next cycle; the sequence restarts from index 0 after the next period.

Source files
------------

// File: rtl/iob_cache_ctrl_sampler.sv
// iob_cache_ctrl_sampler
//
// Periodic statistics sampler for the cache control/counter block. Every
// programmed period it reads the read-hit, read-miss, write-hit and write-miss
// counters through the control block's request port, one request at a time.
// It then publishes all four values together as a coherent snapshot. The
// snapshot is offered to a host with a valid/ready handshake. Three sticky
// flags are kept: a miss alarm, an overrun flag and a reply-timeout error.
//
// Optional feature macro: IOB_CACHE_SAMPLER_AUTO_CLEAR_EN
//   Defined   : after each snapshot the block issues one RST_CNTRS request,
//               so every snapshot covers exactly one period.
//   Undefined : the counters are never reset by this block and accumulate.
//
// Ports
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   enable_i                sampling enable, looked at on period expiry
//   period_i                cycles between sample starts (0 behaves as 1)
//   miss_thresh_i           alarm threshold on rd_miss + wr_miss
//   ctrl_valid_o/addr_o     request strobe and address to the control block
//   ctrl_rdata_i/ready_i    reply data and reply strobe from the control block
//   snap_valid_o/ready_i    snapshot handshake with the host
//   snap_*_o                snapshot fields
//   miss_alarm_o            sticky, snapshot miss sum above threshold
//   overrun_o               sticky, period expired with snapshot still held
//   err_o                   sticky, control block reply timed out
//   clr_flags_i             clears the three sticky flags (a set event wins)

`ifndef IOB_CACHE_SWREG_ADDR_W
`define IOB_CACHE_SWREG_ADDR_W 5
`endif
`ifndef IOB_CACHE_READ_HIT_ADDR
`define IOB_CACHE_READ_HIT_ADDR 4
`endif
`ifndef IOB_CACHE_READ_MISS_ADDR
`define IOB_CACHE_READ_MISS_ADDR 8
`endif
`ifndef IOB_CACHE_WRITE_HIT_ADDR
`define IOB_CACHE_WRITE_HIT_ADDR 12
`endif
`ifndef IOB_CACHE_WRITE_MISS_ADDR
`define IOB_CACHE_WRITE_MISS_ADDR 16
`endif
`ifndef IOB_CACHE_RST_CNTRS_ADDR
`define IOB_CACHE_RST_CNTRS_ADDR 20
`endif

module iob_cache_ctrl_sampler #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TMO_W    = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                enable_i,
  input  logic [PERIOD_W-1:0]                 period_i,
  input  logic [DATA_W-1:0]                   miss_thresh_i,
  output logic                                ctrl_valid_o,
  output logic [`IOB_CACHE_SWREG_ADDR_W-1:0]  ctrl_addr_o,
  input  logic [DATA_W-1:0]                   ctrl_rdata_i,
  input  logic                                ctrl_ready_i,
  output logic                                snap_valid_o,
  input  logic                                snap_ready_i,
  output logic [DATA_W-1:0]                   snap_rd_hit_o,
  output logic [DATA_W-1:0]                   snap_rd_miss_o,
  output logic [DATA_W-1:0]                   snap_wr_hit_o,
  output logic [DATA_W-1:0]                   snap_wr_miss_o,
  output logic                                miss_alarm_o,
  output logic                                overrun_o,
  output logic                                err_o,
  input  logic                                clr_flags_i
);

  localparam int unsigned ADDR_W = `IOB_CACHE_SWREG_ADDR_W;

  // Last timeout count value before giving up: 2^TMO_W-1 waiting cycles total.
  localparam int unsigned TMO_LAST_INT = (1 << TMO_W) - 2;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_INT);

`ifdef IOB_CACHE_SAMPLER_AUTO_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_CLEAR   = 3'd4,
    S_CLRWAIT = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3
  } state_t;
`endif

  state_t              state;
  logic [PERIOD_W-1:0] per_cnt;
  logic [1:0]          idx;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [DATA_W-1:0]   shadow [4];

  logic [PERIOD_W-1:0] period_last;
  logic                period_expired;
  logic [DATA_W:0]     miss_sum;
  logic                alarm_hit;

  // Counter address for each read index.
  function automatic logic [ADDR_W-1:0] idx_addr(input logic [1:0] i);
    logic [ADDR_W-1:0] a;
    case (i)
      2'd0:    a = ADDR_W'(`IOB_CACHE_READ_HIT_ADDR);
      2'd1:    a = ADDR_W'(`IOB_CACHE_READ_MISS_ADDR);
      2'd2:    a = ADDR_W'(`IOB_CACHE_WRITE_HIT_ADDR);
      default: a = ADDR_W'(`IOB_CACHE_WRITE_MISS_ADDR);
    endcase
    return a;
  endfunction

  // Period 0 behaves as 1; >= keeps the counter bounded if period_i shrinks.
  always_comb begin
    period_last    = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    period_expired = (per_cnt >= period_last);
  end

  // Miss sum with carry kept, so a wrapped sum still counts as exceeding.
  always_comb begin
    miss_sum  = {1'b0, shadow[1]} + {1'b0, shadow[3]};
    alarm_hit = (miss_sum > {1'b0, miss_thresh_i});
  end

  // Sampler FSM, period counter, shadow/snapshot registers and sticky flags.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state          <= S_IDLE;
      per_cnt        <= '0;
      idx            <= '0;
      tmo_cnt        <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      ctrl_valid_o   <= 1'b0;
      ctrl_addr_o    <= '0;
      snap_valid_o   <= 1'b0;
      snap_rd_hit_o  <= '0;
      snap_rd_miss_o <= '0;
      snap_wr_hit_o  <= '0;
      snap_wr_miss_o <= '0;
      miss_alarm_o   <= 1'b0;
      overrun_o      <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      // Clear first; any set below is a later assignment and therefore wins.
      if (clr_flags_i) begin
        miss_alarm_o <= 1'b0;
        overrun_o    <= 1'b0;
        err_o        <= 1'b0;
      end

      if (snap_valid_o && snap_ready_i) begin
        snap_valid_o <= 1'b0;
      end

      // Request strobe is a single-cycle pulse.
      ctrl_valid_o <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (period_expired) begin
            per_cnt <= '0;
            if (enable_i) begin
              if (snap_valid_o) begin
                overrun_o <= 1'b1;
              end else begin
                state        <= S_ISSUE;
                idx          <= 2'd0;
                ctrl_valid_o <= 1'b1;
                ctrl_addr_o  <= idx_addr(2'd0);
              end
            end
          end else begin
            per_cnt <= per_cnt + PERIOD_W'(1);
          end
        end

        S_ISSUE: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end

        S_WAIT: begin
          if (ctrl_ready_i) begin
            shadow[idx] <= ctrl_rdata_i;
            if (idx != 2'd3) begin
              idx          <= idx + 2'd1;
              state        <= S_ISSUE;
              ctrl_valid_o <= 1'b1;
              ctrl_addr_o  <= idx_addr(idx + 2'd1);
            end else begin
              state <= S_DONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the sequence; partial shadow data is never published.
            err_o <= 1'b1;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_DONE: begin
          snap_rd_hit_o  <= shadow[0];
          snap_rd_miss_o <= shadow[1];
          snap_wr_hit_o  <= shadow[2];
          snap_wr_miss_o <= shadow[3];
          snap_valid_o   <= 1'b1;
          if (alarm_hit) begin
            miss_alarm_o <= 1'b1;
          end
`ifdef IOB_CACHE_SAMPLER_AUTO_CLEAR_EN
          state        <= S_CLEAR;
          ctrl_valid_o <= 1'b1;
          ctrl_addr_o  <= ADDR_W'(`IOB_CACHE_RST_CNTRS_ADDR);
`else
          state <= S_IDLE;
`endif
        end

`ifdef IOB_CACHE_SAMPLER_AUTO_CLEAR_EN
        S_CLEAR: begin
          state   <= S_CLRWAIT;
          tmo_cnt <= '0;
        end

        S_CLRWAIT: begin
          if (ctrl_ready_i) begin
            state <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
